riscv_retire_unit: RTL and testbench
====================================

# riscv_retire_unit

Commit-stage bookkeeping block inside RISCV_TOP: it observes one retiring instruction per cycle from the pipeline's writeback stage and produces the architectural observation signals the testbenches check, namely NUM_INST, OUTPUT_PORT and HALT. It is the producer end of the NUM_INST/OUTPUT_PORT/HALT checking interface. It owns the retired-instruction counter, the output-port value rules, and the halt-sequence detector FSM.

## Interface
- CNT_W, 32, width of NUM_INST and CYCLE_CNT counters
- HALT_I0, 32'h00c00093, first word of halt sequence (addi x1,x0,12)
- HALT_I1, 32'h00008067, second word of halt sequence (jalr x0,0(x1))

Ports:
- CLK  in  1  clock; single clock domain, all state on posedge
- RST  in  1  asynchronous, active-high reset
- RET_VALID  in  1  an instruction retires this cycle
- RET_INST  in  32  retiring instruction word
- RET_RD_WE  in  1  retiring instruction writes a register (rd may be x0)
- RET_RD_DATA  in  32  value written to rd
- RET_IS_STORE  in  1  retiring instruction is a store
- RET_ST_ADDR  in  32  store effective address
- RET_IS_BRANCH  in  1  retiring instruction is a conditional branch
- RET_BR_TAKEN  in  1  branch outcome
- NUM_INST  out  CNT_W  count of retired instructions
- OUTPUT_PORT  out  32  last observable result
- HALT  out  1  halt sequence retired; sticky
- CYCLE_CNT  out  CNT_W  cycles since reset (see Configuration)

## Operation
- Retirement is accepted only when RET_VALID=1 and the FSM is not HALTED.
- NUM_INST increments by 1 per accepted retirement; it wraps from all-ones to 0.
- OUTPUT_PORT update on an accepted retirement, in priority order:
  - RET_IS_STORE: RET_ST_ADDR
  - RET_IS_BRANCH: {31'b0, RET_BR_TAKEN}
  - RET_RD_WE: RET_RD_DATA; this applies even for rd=x0, and the value is forwarded as given
  - otherwise: unchanged
- If more than one class flag is set, the priority above resolves it and no error is raised.
- Halt FSM states:
  - IDLE: accepted RET_INST==HALT_I0 goes to ARMED.
  - ARMED: accepted RET_INST==HALT_I1 goes to HALTED. Accepted HALT_I0 stays ARMED. Any other accepted instruction goes to IDLE. A cycle with no retirement holds ARMED.
  - HALTED: terminal until RST. All retirement inputs are ignored, and NUM_INST and OUTPUT_PORT are frozen.
- The HALT_I1 instruction itself is counted and applies its OUTPUT_PORT rule (rd_we with rd=x0) before the freeze.
- HALT = (state==HALTED).

## Timing
- All outputs are registered. Effects of a retirement sampled at edge N are visible after edge N.
- HALT rises on the edge that samples the accepted HALT_I1. NUM_INST includes that instruction in the same cycle.
- Reset values: NUM_INST=0, OUTPUT_PORT=0, HALT=0, CYCLE_CNT=0, FSM=IDLE.
- RST asserted mid-run clears all state immediately (asynchronously), with no wait for CLK.
- The first retirement is sampled at the first posedge with RST low.
- No backpressure; one retirement per cycle maximum.

## Configuration
- RETIRE_CYCLE_CNT_EN defined:
  - CYCLE_CNT increments on every posedge while RST=0 and HALT=0.
  - It stops at the value reached on the halting edge, inclusive, and wraps at all-ones.
- RETIRE_CYCLE_CNT_EN undefined: CYCLE_CNT is tied to 0 and no counter flop exists.

## Test plan
- Reset, then 3 retirements: addi rd_we data 5, sw store addr 0xeec, beq taken=0. Required: NUM_INST=1/2/3, OUTPUT_PORT=5/0xeec/0.
- Store and rd_we set together with RET_ST_ADDR=0x10 and RET_RD_DATA=0x20. Required: OUTPUT_PORT=0x10.
- Retire 0x00c00093, idle 2 cycles, then 0x00008067. Required: HALT=1 after that edge; NUM_INST=2; later RET_VALID pulses leave NUM_INST=2.
- Retire 0x00c00093, then 0x00000013, then 0x00008067. Required: HALT stays 0 and NUM_INST=3.
- Assert RST asynchronously mid-run between edges with NUM_INST=7. Required: all outputs 0 before the next edge; counting resumes from 1.
- With RETIRE_CYCLE_CNT_EN, run 10 cycles with halt on the 10th. Required: CYCLE_CNT=10 and held. Without the macro, CYCLE_CNT=0 throughout.

Source files
------------

// File: rtl/riscv_retire_unit.sv
// rtl/riscv_retire_unit.sv - commit-stage retirement bookkeeping (NUM_INST, OUTPUT_PORT, HALT)
//
// Observes at most one retiring instruction per cycle from writeback and
// keeps the architectural observation state used by the checking harness.
//
// Optional feature macro: RETIRE_CYCLE_CNT_EN (enables the CYCLE_CNT counter;
// when undefined CYCLE_CNT is tied to zero and no counter flop exists).
//
// Parameters:
//   CNT_W    width of NUM_INST and CYCLE_CNT
//   HALT_I0  first word of the halt sequence  (addi x1,x0,12)
//   HALT_I1  second word of the halt sequence (jalr x0,0(x1))
//
// Ports:
//   CLK            in   clock, all state on posedge
//   RST            in   asynchronous active-high reset
//   RET_VALID      in   an instruction retires this cycle
//   RET_INST       in   retiring instruction word
//   RET_RD_WE      in   retiring instruction writes rd (rd may be x0)
//   RET_RD_DATA    in   value written to rd
//   RET_IS_STORE   in   retiring instruction is a store
//   RET_ST_ADDR    in   store effective address
//   RET_IS_BRANCH  in   retiring instruction is a conditional branch
//   RET_BR_TAKEN   in   branch outcome
//   NUM_INST       out  retired-instruction count (wraps)
//   OUTPUT_PORT    out  last observable result
//   HALT           out  halt sequence retired (sticky until RST)
//   CYCLE_CNT      out  cycles since reset, frozen after halt
module riscv_retire_unit #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] HALT_I0 = 32'h00c00093,
    parameter logic [31:0] HALT_I1 = 32'h00008067
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RET_VALID,
    input  logic [31:0]      RET_INST,
    input  logic             RET_RD_WE,
    input  logic [31:0]      RET_RD_DATA,
    input  logic             RET_IS_STORE,
    input  logic [31:0]      RET_ST_ADDR,
    input  logic             RET_IS_BRANCH,
    input  logic             RET_BR_TAKEN,
    output logic [CNT_W-1:0] NUM_INST,
    output logic [31:0]      OUTPUT_PORT,
    output logic             HALT,
    output logic [CNT_W-1:0] CYCLE_CNT
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;

    // Once halted, every retirement input is ignored.
    assign accept = RET_VALID && (state != S_HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && RET_INST == HALT_I0) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                // Idle cycles keep the sequence armed; a repeated HALT_I0
                // re-arms; anything else breaks the sequence.
                if (accept) begin
                    if (RET_INST == HALT_I1) begin
                        state_next = S_HALTED;
                    end else if (RET_INST == HALT_I0) begin
                        state_next = S_ARMED;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign HALT = (state == S_HALTED);

    // The halting instruction is still accepted, so it is counted and its
    // result reaches OUTPUT_PORT on the same edge that raises HALT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            NUM_INST    <= '0;
            OUTPUT_PORT <= '0;
        end else if (accept) begin
            NUM_INST <= NUM_INST + CNT_W'(1);
            if (RET_IS_STORE) begin
                OUTPUT_PORT <= RET_ST_ADDR;
            end else if (RET_IS_BRANCH) begin
                OUTPUT_PORT <= {31'b0, RET_BR_TAKEN};
            end else if (RET_RD_WE) begin
                OUTPUT_PORT <= RET_RD_DATA;
            end
        end
    end

`ifdef RETIRE_CYCLE_CNT_EN
    // Counts the halting edge itself (state is not yet HALTED there), then stops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CYCLE_CNT <= '0;
        end else if (state != S_HALTED) begin
            CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
        end
    end
`else
    assign CYCLE_CNT = '0;
`endif

endmodule

// File: tb/tb_riscv_retire_unit.sv
// tb/tb_riscv_retire_unit.sv - self-checking bench for riscv_retire_unit
module tb_riscv_retire_unit;

    localparam int          CNT_W = 32;
    localparam logic [31:0] I0    = 32'h00c00093;
    localparam logic [31:0] I1    = 32'h00008067;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             CLK;
    logic             RST;
    logic             RET_VALID;
    logic [31:0]      RET_INST;
    logic             RET_RD_WE;
    logic [31:0]      RET_RD_DATA;
    logic             RET_IS_STORE;
    logic [31:0]      RET_ST_ADDR;
    logic             RET_IS_BRANCH;
    logic             RET_BR_TAKEN;
    logic [CNT_W-1:0] NUM_INST;
    logic [31:0]      OUTPUT_PORT;
    logic             HALT;
    logic [CNT_W-1:0] CYCLE_CNT;

    int tests = 0;
    int fails = 0;

    riscv_retire_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .RET_VALID(RET_VALID), .RET_INST(RET_INST),
        .RET_RD_WE(RET_RD_WE), .RET_RD_DATA(RET_RD_DATA),
        .RET_IS_STORE(RET_IS_STORE), .RET_ST_ADDR(RET_ST_ADDR),
        .RET_IS_BRANCH(RET_IS_BRANCH), .RET_BR_TAKEN(RET_BR_TAKEN),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT),
        .HALT(HALT), .CYCLE_CNT(CYCLE_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: halt is declared when an accepted HALT_I1 directly
    // follows an accepted HALT_I0 in the stream of accepted instructions.
    logic [CNT_W-1:0] m_num;
    logic [31:0]      m_out;
    logic             m_halt;
    logic [CNT_W-1:0] m_cyc;
    logic [31:0]      m_last;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_num  <= '0;
            m_out  <= '0;
            m_halt <= 1'b0;
            m_cyc  <= '0;
            m_last <= '0;
        end else begin
            if (!m_halt) m_cyc <= m_cyc + 1;
            if (RET_VALID && !m_halt) begin
                m_num <= m_num + 1;
                if (RET_IS_STORE)       m_out <= RET_ST_ADDR;
                else if (RET_IS_BRANCH) m_out <= {31'b0, RET_BR_TAKEN};
                else if (RET_RD_WE)     m_out <= RET_RD_DATA;
                if (RET_INST == I1 && m_last == I0) m_halt <= 1'b1;
                m_last <= RET_INST;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            check("num_inst", 64'(NUM_INST), 64'(m_num));
            check("output_port", 64'(OUTPUT_PORT), 64'(m_out));
            check("halt", 64'(HALT), 64'(m_halt));
`ifdef RETIRE_CYCLE_CNT_EN
            check("cycle_cnt", 64'(CYCLE_CNT), 64'(m_cyc));
`else
            check("cycle_cnt", 64'(CYCLE_CNT), 64'd0);
`endif
        end
    end

    task automatic clear_inputs();
        RET_VALID = 0; RET_INST = 0; RET_RD_WE = 0; RET_RD_DATA = 0;
        RET_IS_STORE = 0; RET_ST_ADDR = 0; RET_IS_BRANCH = 0; RET_BR_TAKEN = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic ret(input logic [31:0] inst, input logic we, input logic [31:0] data,
                       input logic st, input logic [31:0] addr, input logic br, input logic tk);
        RET_VALID = 1; RET_INST = inst; RET_RD_WE = we; RET_RD_DATA = data;
        RET_IS_STORE = st; RET_ST_ADDR = addr; RET_IS_BRANCH = br; RET_BR_TAKEN = tk;
        @(posedge CLK);
        #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        #2;
        do_reset();
        check("reset_num", 64'(NUM_INST), 64'd0);
        check("reset_out", 64'(OUTPUT_PORT), 64'd0);
        check("reset_halt", 64'(HALT), 64'd0);
        check("reset_cyc", 64'(CYCLE_CNT), 64'd0);

        // Basic classes
        ret(32'h00500093, 1, 32'd5, 0, 0, 0, 0);
        check("t1_num", 64'(NUM_INST), 64'd1);
        check("t1_out", 64'(OUTPUT_PORT), 64'd5);
        ret(32'h00b02623, 0, 0, 1, 32'h0000_0eec, 0, 0);
        check("t2_num", 64'(NUM_INST), 64'd2);
        check("t2_out", 64'(OUTPUT_PORT), 64'h0eec);
        ret(32'h00000463, 0, 0, 0, 0, 1, 0);
        check("t3_num", 64'(NUM_INST), 64'd3);
        check("t3_out", 64'(OUTPUT_PORT), 64'd0);

        // Priority resolution
        ret(32'h01002023, 1, 32'h20, 1, 32'h10, 0, 0);
        check("prio_store", 64'(OUTPUT_PORT), 64'h10);
        ret(32'h00000463, 1, 32'h55, 0, 0, 1, 1);
        check("prio_branch", 64'(OUTPUT_PORT), 64'd1);
        ret(32'h0000000f, 0, 32'h99, 0, 0, 0, 0);
        check("no_class", 64'(OUTPUT_PORT), 64'd1);
        check("t6_num", 64'(NUM_INST), 64'd6);

        // Broken halt sequence
        do_reset();
        ret(I0, 1, 32'd12, 0, 0, 0, 0);
        ret(NOP, 1, 32'd0, 0, 0, 0, 0);
        ret(I1, 1, 32'h1234, 0, 0, 0, 0);
        check("broken_halt", 64'(HALT), 64'd0);
        check("broken_num", 64'(NUM_INST), 64'd3);
        check("broken_out", 64'(OUTPUT_PORT), 64'h1234);

        // Asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 7; i++) ret(NOP, 1, 32'(i + 1), 0, 0, 0, 0);
        check("pre_arst_num", 64'(NUM_INST), 64'd7);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("arst_num", 64'(NUM_INST), 64'd0);
        check("arst_out", 64'(OUTPUT_PORT), 64'd0);
        check("arst_halt", 64'(HALT), 64'd0);
        check("arst_cyc", 64'(CYCLE_CNT), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        ret(NOP, 1, 32'h42, 0, 0, 0, 0);
        check("post_arst_num", 64'(NUM_INST), 64'd1);

        // Halt on the 10th edge after reset, with idle cycles while armed
        do_reset();
        idle(6);
        ret(I0, 1, 32'd12, 0, 0, 0, 0);
        idle(2);
        ret(I1, 1, 32'h77, 0, 0, 0, 0);
        check("halt_set", 64'(HALT), 64'd1);
        check("halt_num", 64'(NUM_INST), 64'd2);
        check("halt_out", 64'(OUTPUT_PORT), 64'h77);
`ifdef RETIRE_CYCLE_CNT_EN
        check("halt_cyc", 64'(CYCLE_CNT), 64'd10);
`else
        check("halt_cyc", 64'(CYCLE_CNT), 64'd0);
`endif
        ret(NOP, 1, 32'h5, 0, 0, 0, 0);
        ret(I0, 0, 0, 1, 32'hdead, 0, 0);
        ret(I1, 0, 0, 0, 0, 1, 1);
        idle(3);
        check("frozen_num", 64'(NUM_INST), 64'd2);
        check("frozen_out", 64'(OUTPUT_PORT), 64'h77);
        check("frozen_halt", 64'(HALT), 64'd1);
`ifdef RETIRE_CYCLE_CNT_EN
        check("frozen_cyc", 64'(CYCLE_CNT), 64'd10);
`else
        check("frozen_cyc", 64'(CYCLE_CNT), 64'd0);
`endif

        @(posedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
